// File: rtl/mdu_ctrl_if.sv
// Execute-stage MDU handshake: E-stage operation request, D-stage hazard input,
// and the HI/LO, busy and stall results returned to the pipeline.
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        md_use_D;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  modport master (
    output start, op, src_a, src_b, md_use_D,
    input  hi, lo, busy, stall
  );

  modport slave (
    input  start, op, src_a, src_b, md_use_D,
    output hi, lo, busy, stall
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO, with pipeline stall generation.
// Optional madd/maddu accumulate ops are enabled by defining MDU_MADD_EN.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset_n,
  mdu_ctrl_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_MADD  = 3'b110,
    OP_MADDU = 3'b111
  } op_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [63:0] pending;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;

  op_t         op;
  logic        multi_op;
  logic [3:0]  load_cnt;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [63:0] result;

  assign op = op_t'(bus.op);

  always_comb begin
    prod_s = $signed({{32{bus.src_a[31]}}, bus.src_a}) * $signed({{32{bus.src_b[31]}}, bus.src_b});
    prod_u = {32'd0, bus.src_a} * {32'd0, bus.src_b};
  end

  // Divide-by-zero and the signed overflow case are resolved explicitly so the
  // result never depends on the divider's behaviour for those operands.
  always_comb begin
    quot = '0;
    rem  = '0;
    if (bus.src_b == '0) begin
      quot = '1;
      rem  = bus.src_a;
    end else if (op == OP_DIV) begin
      if (bus.src_a == 32'h8000_0000 && bus.src_b == '1) begin
        quot = 32'h8000_0000;
        rem  = '0;
      end else begin
        quot = $signed(bus.src_a) / $signed(bus.src_b);
        rem  = $signed(bus.src_a) % $signed(bus.src_b);
      end
    end else begin
      quot = bus.src_a / bus.src_b;
      rem  = bus.src_a % bus.src_b;
    end
  end

  always_comb begin
    result   = '0;
    multi_op = 1'b0;
    case (op)
      OP_MULT:  begin result = prod_s;      multi_op = 1'b1; end
      OP_MULTU: begin result = prod_u;      multi_op = 1'b1; end
      OP_DIV,
      OP_DIVU:  begin result = {rem, quot}; multi_op = 1'b1; end
`ifdef MDU_MADD_EN
      OP_MADD:  begin result = {hi_q, lo_q} + prod_s; multi_op = 1'b1; end
      OP_MADDU: begin result = {hi_q, lo_q} + prod_u; multi_op = 1'b1; end
`endif
      default:  begin result = '0;          multi_op = 1'b0; end
    endcase
    load_cnt = (op == OP_DIV || op == OP_DIVU) ? 4'(DIV_CYCLES - 1) : 4'(MULT_CYCLES - 1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      pending <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (op == OP_MTHI) begin
              hi_q <= bus.src_a;
            end else if (op == OP_MTLO) begin
              lo_q <= bus.src_a;
            end else if (multi_op) begin
              pending <= result;
              cnt     <= load_cnt;
              busy_q  <= 1'b1;
              state   <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            hi_q   <= pending[63:32];
            lo_q   <= pending[31:0];
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = busy_q;
  assign bus.stall = bus.md_use_D & (busy_q | (bus.start & multi_op));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus randomized ops
// checked against an arithmetic reference model of HI/LO and busy timing.
module tb_mdu_ctrl;
  localparam int unsigned MULT = 5;
  localparam int unsigned DIV  = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mdu_ctrl_if bus();

  mdu_ctrl #(.MULT_CYCLES(MULT), .DIV_CYCLES(DIV)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int vectors = 0;
  int errors  = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  function automatic bit is_multi(input logic [2:0] o);
`ifdef MDU_MADD_EN
    return (o != 3'd4) && (o != 3'd5);
`else
    return o < 3'd4;
`endif
  endfunction

  function automatic int unsigned cycles(input logic [2:0] o);
    return (o == 3'd2 || o == 3'd3) ? DIV : MULT;
  endfunction

  // Expected {hi,lo} after the op completes, using 64-bit integer arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] h, input logic [31:0] l);
    int ia, ib;
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur, sprod, uprod;
    ia = a; ib = b; sa = ia; sb = ib;
    ua = {32'd0, a}; ub = {32'd0, b};
    sprod = sa * sb;
    uprod = ua * ub;
    case (o)
      3'd0: return sprod;
      3'd1: return uprod;
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sq = sa / sb; sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub; ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      3'd4: return {a, l};
      3'd5: return {h, a};
      default: begin
`ifdef MDU_MADD_EN
        return {h, l} + ((o == 3'd6) ? sprod : uprod);
`else
        return {h, l};
`endif
      end
    endcase
  endfunction

  task automatic apply_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic use_d);
    logic [63:0] exp;
    bit mc;
    int unsigned n;
    mc  = is_multi(o);
    n   = cycles(o);
    exp = model(o, a, b, m_hi, m_lo);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = b; bus.md_use_D = use_d;
    #1;
    vectors++;
    if (bus.stall !== (use_d & mc)) begin
      errors++;
      $display("FAIL stall_start op=%0d got %b want %b", o, bus.stall, use_d & mc);
    end
    @(negedge clk);
    bus.start = 1'b0; bus.src_a = $urandom; bus.src_b = $urandom;
    if (mc) begin
      for (int unsigned i = 0; i < n; i++) begin
        vectors++;
        if (bus.busy !== 1'b1 || bus.stall !== use_d || bus.hi !== m_hi || bus.lo !== m_lo) begin
          errors++;
          $display("FAIL busy_hold op=%0d cyc=%0d got busy=%b stall=%b hi=%h lo=%h want busy=1 stall=%b hi=%h lo=%h",
                   o, i, bus.busy, bus.stall, bus.hi, bus.lo, use_d, m_hi, m_lo);
        end
        @(negedge clk);
      end
    end
    vectors++;
    if (bus.busy !== 1'b0 || bus.stall !== 1'b0 || {bus.hi, bus.lo} !== exp) begin
      errors++;
      $display("FAIL result op=%0d a=%h b=%h got busy=%b stall=%b hi=%h lo=%h want busy=0 stall=0 hi=%h lo=%h",
               o, a, b, bus.busy, bus.stall, bus.hi, bus.lo, exp[63:32], exp[31:0]);
    end
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op = '0; bus.src_a = '0; bus.src_b = '0; bus.md_use_D = 1'b1;
    reset_n = 1'b0;
    #12;
    vectors++;
    if (bus.hi !== '0 || bus.lo !== '0 || bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL reset got hi=%h lo=%h busy=%b stall=%b want all zero", bus.hi, bus.lo, bus.busy, bus.stall);
    end
    @(negedge clk);
    reset_n = 1'b1;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_directed();
    apply_op(3'd4, 32'h1234_5678, 32'h0, 1'b1);
    apply_op(3'd0, 32'd3, 32'hFFFF_FFFE, 1'b0);
    apply_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1);
    apply_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
    apply_op(3'd5, 32'hCAFE_F00D, 32'h0, 1'b1);
    apply_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    apply_op(3'd2, 32'd7, 32'hFFFF_FFFE, 1'b0);
    apply_op(3'd2, 32'hDEAD_BEEF, 32'd0, 1'b0);
  endtask

  task automatic test_reset_abort();
    apply_op(3'd3, 32'd5, 32'd0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd2; bus.src_a = 32'd100; bus.src_b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy_before got %b want 1", bus.busy);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.hi !== '0 || bus.lo !== '0) begin
      errors++;
      $display("FAIL abort_reset got busy=%b hi=%h lo=%h want 0 0 0", bus.busy, bus.hi, bus.lo);
    end
    @(negedge clk);
    reset_n = 1'b1;
    m_hi = '0; m_lo = '0;
    repeat (DIV + 2) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0 || bus.hi !== '0 || bus.lo !== '0) begin
      errors++;
      $display("FAIL abort_stays got busy=%b hi=%h lo=%h want 0 0 0", bus.busy, bus.hi, bus.lo);
    end
  endtask

  task automatic test_start_while_busy();
    logic [63:0] exp;
    exp = model(3'd1, 32'h0001_0000, 32'h0001_0000, m_hi, m_lo);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd1; bus.src_a = 32'h0001_0000; bus.src_b = 32'h0001_0000; bus.md_use_D = 1'b0;
    @(negedge clk);
    bus.op = 3'd4; bus.src_a = 32'h5555_AAAA;
    @(negedge clk);
    bus.op = 3'd2; bus.src_b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (MULT) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0 || {bus.hi, bus.lo} !== exp) begin
      errors++;
      $display("FAIL start_while_busy got busy=%b hi=%h lo=%h want busy=0 hi=%h lo=%h",
               bus.busy, bus.hi, bus.lo, exp[63:32], exp[31:0]);
    end
    m_hi = exp[63:32]; m_lo = exp[31:0];
  endtask

  task automatic test_madd();
    apply_op(3'd4, 32'h0, 32'h0, 1'b0);
    apply_op(3'd5, 32'hFFFF_FFFF, 32'h0, 1'b0);
    apply_op(3'd7, 32'd1, 32'd1, 1'b1);
    apply_op(3'd6, 32'hFFFF_FFFF, 32'd3, 1'b1);
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = '1; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      apply_op(o, a, b, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_abort();
    test_start_while_busy();
    test_madd();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multiply/divide sequencer for the execute stage; owns HI/LO and models a multi-cycle MDU shared by mult/multu/div/divu/mthi/mtlo.
Accepts an operation from E using the forwarded operands (post-ForwardAE/ForwardBE values) and holds HI/LO until commit.
Drives the pipeline stall so that a decode-stage MD instruction cannot enter E while the unit is busy.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1-15)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1-15)

Ports:
clk  input  1  pipeline clock, rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  E-stage instruction is an MD op; sampled on the rising edge
op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 madd, 111 maddu
src_a  input  32  forwarded rs value from the E stage
src_b  input  32  forwarded rt value from the E stage
md_use_D  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo/madd/maddu
hi  output  32  HI register
lo  output  32  LO register
busy  output  1  multi-cycle operation in progress
stall  output  1  freeze PC/D, bubble into E

Behaviour:
- Reset (async, reset_n low): hi=0, lo=0, busy=0, counter=0, pending result=0, state IDLE. Reset mid-operation aborts the operation; HI/LO stay 0.
- States: IDLE and BUSY, with a 4-bit down-counter cnt.
- IDLE, start=1, op mthi/mtlo: hi or lo <= src_a at that edge; no busy; state stays IDLE.
- IDLE, start=1, op mult/multu/div/divu: compute the result from src_a/src_b at that edge into a pending 64-bit register; busy=1; cnt=N-1 (N=MULT_CYCLES or DIV_CYCLES); go to BUSY.
- BUSY: cnt decrements each edge. On the edge where cnt==0: hi/lo <= pending, busy=0, go to IDLE. busy is high for exactly N cycles, and the new hi/lo are visible in the first cycle busy is low.
- mult: signed 32x32->64 product. multu: unsigned product. hi = upper 32 bits, lo = lower 32 bits.
- div: signed; lo=quotient, hi=remainder. Quotient truncates toward zero; the remainder takes the sign of the dividend.
- divu: unsigned. Otherwise the same as div.
- Divide by zero: hi=src_a, lo=32'hFFFF_FFFF. Busy timing is unchanged.
- div 0x80000000 / -1: lo=0x80000000, hi=0.
- start while BUSY (should not occur because of stall): ignored; no state change.
- stall = md_use_D & (busy | (start & op is a multi-cycle op)). This is combinational and has no other terms.
- mfhi/mflo read hi/lo directly. The stall guarantees they never observe a pending value.
- Ops 110/111 without the optional feature: start is ignored. The op is treated as a nop: no busy and no stall contribution.

Optional Feature:
MDU_MADD_EN.
- Defined: madd/maddu are valid multi-cycle ops using MULT_CYCLES. pending = {hi,lo} + product, with the product signed for madd and unsigned for maddu, mod 2^64. The {hi,lo} value used is the one at the start edge.
- Undefined: 110/111 behave as nops per Behaviour, and no 64-bit adder is synthesized.

Test Plan:
- Reset release then mthi src_a=0x12345678 -> hi=0x12345678 next cycle; busy stays 0; stall=0.
- mult src_a=3, src_b=0xFFFFFFFE -> busy high 5 cycles; hi/lo unchanged while busy; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu src_a=0xFFFFFFFF, src_b=2 -> after 5 cycles hi=1, lo=0xFFFFFFFE.
- div src_a=0xFFFFFFF9 (-7), src_b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. Holding md_use_D=1 keeps stall=1 from the start cycle through the last busy cycle, then stall=0.
- divu src_a=5, src_b=0 -> hi=5, lo=0xFFFFFFFF after 10 cycles. Pulse reset_n low during a second div -> busy=0, hi=lo=0 immediately.
- With MDU_MADD_EN, hi=0, lo=0xFFFFFFFF, maddu 1*1 -> hi=1, lo=0. Without the macro the same stimulus leaves hi/lo unchanged and busy=0.
